// File: rtl/sw_handshake_conditioner.sv
// Synchronises the raw DE0 switches, debounces the handshake switch and
// captures the data byte once per accepted handshake assertion.
module sw_handshake_conditioner #(
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic                  sw_handshake,
  input  logic [DATA_WIDTH-1:0] sw_data,
  output logic                  io_handshake,
  output logic [DATA_WIDTH-1:0] in_bus,
  output logic                  latch_strobe,
  output logic                  release_strobe
);

  localparam int unsigned       CNT_W   = 8;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RISE = 2'd1;
  localparam logic [1:0] ST_HELD = 2'd2;
  localparam logic [1:0] ST_FALL = 2'd3;

  logic [SYNC_STAGES-1:0]                 hs_sync_q;
  logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] data_sync_q;

  logic [1:0]            state_q,   state_d;
  logic [CNT_W-1:0]      cnt_q,     cnt_d;
  logic                  io_q,      io_d;
  logic [DATA_WIDTH-1:0] in_bus_q,  in_bus_d;
  logic                  latch_q,   latch_d;
  logic                  release_q, release_d;

  logic                  s_c;
  logic [DATA_WIDTH-1:0] d_c;

  assign s_c = hs_sync_q[SYNC_STAGES-1];
  assign d_c = data_sync_q[SYNC_STAGES-1];

  // Synchroniser chains; stage 0 samples the raw switches.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      hs_sync_q   <= '0;
      data_sync_q <= '0;
    end else begin
      hs_sync_q   <= {hs_sync_q[SYNC_STAGES-2:0], sw_handshake};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], sw_data};
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      io_q      <= 1'b0;
      in_bus_q  <= '0;
      latch_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      io_q      <= io_d;
      in_bus_q  <= in_bus_d;
      latch_q   <= latch_d;
      release_q <= release_d;
    end
  end

  // Debounce FSM: a glitch back to the old level restarts from the old state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    in_bus_d  = in_bus_q;
    latch_d   = 1'b0;
    release_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (s_c) begin
          state_d = ST_RISE;
          cnt_d   = 8'd1;
        end
      end
      ST_RISE: begin
        if (!s_c) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d  = ST_HELD;
          in_bus_d = d_c;
          latch_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_HELD: begin
        if (!s_c) begin
          state_d = ST_FALL;
          cnt_d   = 8'd1;
        end
      end
      ST_FALL: begin
        if (s_c) begin
          state_d = ST_HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d   = ST_IDLE;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    io_d = (state_d == ST_HELD) || (state_d == ST_FALL);
  end

  assign io_handshake   = io_q;
  assign in_bus         = in_bus_q;
  assign latch_strobe   = latch_q;
  assign release_strobe = release_q;

endmodule

// File: tb/tb_sw_handshake_conditioner.sv
// Directed bench for sw_handshake_conditioner at default parameters:
// rise/fall latency is 7 edges after a stable switch level.
module tb_sw_handshake_conditioner;

  logic       clk;
  logic       n_reset;
  logic       sw_handshake;
  logic [7:0] sw_data;
  logic       io_handshake;
  logic [7:0] in_bus;
  logic       latch_strobe;
  logic       release_strobe;

  int vectors;
  int miscompares;
  int lat_cnt;
  int rel_cnt;
  int both_cnt;

  sw_handshake_conditioner #(
    .DATA_WIDTH     (8),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk           (clk),
    .n_reset       (n_reset),
    .sw_handshake  (sw_handshake),
    .sw_data       (sw_data),
    .io_handshake  (io_handshake),
    .in_bus        (in_bus),
    .latch_strobe  (latch_strobe),
    .release_strobe(release_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then sample 1 time unit later and tally strobes.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      lat_cnt  += int'(latch_strobe);
      rel_cnt  += int'(release_strobe);
      both_cnt += int'(latch_strobe & release_strobe);
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    lat_cnt = 0; rel_cnt = 0; both_cnt = 0;
    n_reset = 1'b0; sw_handshake = 1'b1; sw_data = 8'hFF;

    // Reset held with switches high: everything stays zero.
    step(3);
    check("rst_io",    32'(io_handshake),   32'd0);
    check("rst_bus",   32'(in_bus),         32'h00);
    check("rst_latch", 32'(latch_strobe),   32'd0);
    check("rst_rel",   32'(release_strobe), 32'd0);

    // Release reset with switch still high: re-debounced, accepted at edge 7.
    n_reset = 1'b1; lat_cnt = 0; rel_cnt = 0;
    step(6);
    check("rst_rise_io_e6",  32'(io_handshake), 32'd0);
    check("rst_rise_lat_e6", 32'(lat_cnt),      32'd0);
    step(1);
    check("rst_rise_io_e7",  32'(io_handshake), 32'd1);
    check("rst_rise_bus_e7", 32'(in_bus),       32'hFF);
    check("rst_rise_lat_e7", 32'(latch_strobe), 32'd1);
    step(1);
    check("rst_rise_lat_w",  32'(latch_strobe), 32'd0);
    check("rst_rise_lat_n",  32'(lat_cnt),      32'd1);

    // Fall back to IDLE; data change during HELD/FALL must not capture.
    sw_handshake = 1'b0; sw_data = 8'h5A;
    step(6);
    check("fall1_io_e6",  32'(io_handshake),   32'd1);
    step(1);
    check("fall1_io_e7",  32'(io_handshake),   32'd0);
    check("fall1_rel_e7", 32'(release_strobe), 32'd1);
    check("fall1_bus",    32'(in_bus),         32'hFF);
    step(1);
    check("fall1_rel_w",  32'(release_strobe), 32'd0);

    // Clean transfer of 8'h5A, high 20 cycles.
    lat_cnt = 0; rel_cnt = 0;
    sw_handshake = 1'b1;
    step(6);
    check("clean_lat_e6", 32'(latch_strobe), 32'd0);
    step(1);
    check("clean_lat_e7", 32'(latch_strobe), 32'd1);
    check("clean_bus_e7", 32'(in_bus),       32'h5A);
    check("clean_io_e7",  32'(io_handshake), 32'd1);
    step(13);
    sw_handshake = 1'b0;
    step(6);
    check("clean_rel_e6", 32'(release_strobe), 32'd0);
    step(1);
    check("clean_rel_e7", 32'(release_strobe), 32'd1);
    check("clean_io_off", 32'(io_handshake),   32'd0);
    step(5);
    check("clean_bus_hold", 32'(in_bus),  32'h5A);
    check("clean_lat_n",    32'(lat_cnt), 32'd1);
    check("clean_rel_n",    32'(rel_cnt), 32'd1);

    // Bounce on rise: 1,0,1,1,0 then stable 1.
    lat_cnt = 0;
    sw_handshake = 1'b1; step(1);
    sw_handshake = 1'b0; step(1);
    sw_handshake = 1'b1; step(1);
    step(1);
    sw_handshake = 1'b0; step(1);
    sw_handshake = 1'b1;
    step(6);
    check("bounce_lat_none", 32'(lat_cnt),      32'd0);
    check("bounce_io_e6",    32'(io_handshake), 32'd0);
    step(1);
    check("bounce_lat_e7",   32'(latch_strobe), 32'd1);
    check("bounce_io_e7",    32'(io_handshake), 32'd1);
    check("bounce_bus",      32'(in_bus),       32'h5A);

    // Glitch low for 3 cycles while HELD, with new data on the switches.
    lat_cnt = 0; rel_cnt = 0;
    sw_data = 8'h33;
    sw_handshake = 1'b0;
    step(3);
    sw_handshake = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1);
      check("glitch_io_hold", 32'(io_handshake), 32'd1);
    end
    check("glitch_rel_n", 32'(rel_cnt), 32'd0);
    check("glitch_lat_n", 32'(lat_cnt), 32'd0);
    check("glitch_bus",   32'(in_bus),  32'h5A);

    // Reset while in FALL: outputs clear, no release strobe afterwards.
    rel_cnt = 0;
    sw_handshake = 1'b0;
    step(4);
    check("midrst_pre_io", 32'(io_handshake), 32'd1);
    n_reset = 1'b0;
    step(1);
    check("midrst_io",  32'(io_handshake),   32'd0);
    check("midrst_bus", 32'(in_bus),         32'h00);
    check("midrst_rel", 32'(release_strobe), 32'd0);
    n_reset = 1'b1;
    step(10);
    check("midrst_rel_n", 32'(rel_cnt),      32'd0);
    check("midrst_io_n",  32'(io_handshake), 32'd0);

    // Back-to-back transfers of 8'h01 then 8'h02.
    lat_cnt = 0; rel_cnt = 0;
    sw_data = 8'h01; sw_handshake = 1'b1;
    step(7);
    check("b2b1_lat", 32'(latch_strobe), 32'd1);
    check("b2b1_bus", 32'(in_bus),       32'h01);
    step(3);
    sw_handshake = 1'b0;
    step(7);
    check("b2b1_rel", 32'(release_strobe), 32'd1);
    sw_data = 8'h02; sw_handshake = 1'b1;
    step(7);
    check("b2b2_lat", 32'(latch_strobe), 32'd1);
    check("b2b2_bus", 32'(in_bus),       32'h02);
    step(3);
    sw_handshake = 1'b0;
    step(7);
    check("b2b2_rel",   32'(release_strobe), 32'd1);
    step(2);
    check("b2b_lat_n",  32'(lat_cnt),      32'd2);
    check("b2b_rel_n",  32'(rel_cnt),      32'd2);
    check("b2b_io_end", 32'(io_handshake), 32'd0);
    check("b2b_bus_end", 32'(in_bus),      32'h02);

    check("strobes_overlap", 32'(both_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
